// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
// Imported by the storage array and the responder FSM.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W    = 4;
  localparam int WORD_LSB = 2;
  localparam int DATA_W   = 32;

  // Word address width for a given depth.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read.
// Contents are never cleared by reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [AW-1:0]     widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Commit a write at the rising edge.
  always_ff @(posedge clk) begin
    if (wen) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed wait states.
// Registered ack/err/rd; range and alignment checked per access.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = addr_w(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lwe;
  logic [31:0]       la;
  logic [31:0]       lwd;

  logic [31:0]       chk_a;
  logic              chk_we;
  logic              chk_bad;
  logic [AW-1:0]     ridx;
  logic [31:0]       rdata;
  logic              l_bad;
  logic              wen;

  // Pick the access that will complete next: the live request when
  // going straight to RESP from IDLE, otherwise the latched one.
  always_comb begin
    chk_a  = la;
    chk_we = lwe;
    if (state == IDLE) begin
      chk_a  = a;
      chk_we = we;
    end
    chk_bad = (chk_a[1:0] != 2'b00) ||
              ((chk_a >> (AW + WORD_LSB)) != 32'd0);
    ridx    = chk_a[AW+1:WORD_LSB];
  end

  assign l_bad = (la[1:0] != 2'b00) ||
                 ((la >> (AW + WORD_LSB)) != 32'd0);

  // Writes land at the edge closing RESP; reset discards them.
  assign wen = (state == RESP) && lwe && !l_bad && !reset;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .wen  (wen),
    .widx (la[AW+1:WORD_LSB]),
    .wdata(lwd),
    .ridx (ridx),
    .rdata(rdata)
  );

  assign busy = (state != IDLE);

  // Request FSM with registered completion outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rd    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            lwe <= we;
            la  <= a;
            lwd <= wd;
            cnt <= CNT_LOAD;
            if (LATENCY == 1) begin
              state <= RESP;
              ack   <= 1'b1;
              err   <= chk_bad;
              if (chk_bad)      rd <= '0;
              else if (!chk_we) rd <= rdata;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state <= RESP;
            ack   <= 1'b1;
            err   <= chk_bad;
            if (chk_bad)      rd <= '0;
            else if (!chk_we) rd <= rdata;
          end
        end
        RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder at latencies 1, 2, 4 and 15.
// Directed steps plus random accesses against an array model.
module tb_mem_responder;

  localparam int N = 4;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 15;
    endcase
  endfunction

  logic        clk;
  logic        reset;
  logic        req  [N];
  logic        we   [N];
  logic [31:0] a    [N];
  logic [31:0] wd   [N];
  logic [31:0] rd   [N];
  logic        ack  [N];
  logic        err  [N];
  logic        busy [N];

  logic [31:0] mdl     [N][64];
  logic [31:0] last_rd [N];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS(64),
      .LATENCY    (lat_of(g))
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .req  (req[g]),
      .we   (we[g]),
      .a    (a[g]),
      .wd   (wd[g]),
      .rd   (rd[g]),
      .ack  (ack[g]),
      .err  (err[g]),
      .busy (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] ad);
    return (ad % 4 != 0) || (ad >= 32'd256);
  endfunction

  // One full access on instance i; optionally moves the address mid-flight.
  task automatic xfer(input int i, input bit w, input logic [31:0] ad,
                      input logic [31:0] dat, input int chg_cyc,
                      input logic [31:0] chg_ad);
    int          lat;
    bit          e_err;
    logic [31:0] e_rd;
    lat = lat_of(i);
    @(negedge clk);
    req[i] = 1'b1;
    we[i]  = w;
    a[i]   = ad;
    wd[i]  = dat;
    e_err  = addr_bad(ad);
    if (e_err)  e_rd = 32'd0;
    else if (w) e_rd = last_rd[i];
    else        e_rd = mdl[i][ad / 4];
    if (w && !e_err) mdl[i][ad / 4] = dat;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == chg_cyc) begin
        a[i]  = chg_ad;
        wd[i] = $urandom;
        we[i] = ~we[i];
      end
      check($sformatf("busy i%0d c%0d", i, c), {31'd0, busy[i]},
            {31'd0, c <= lat});
      check($sformatf("ack i%0d c%0d", i, c), {31'd0, ack[i]},
            {31'd0, c == lat});
      if (c == lat) begin
        check($sformatf("err i%0d a%h", i, ad), {31'd0, err[i]},
              {31'd0, e_err});
        check($sformatf("rd i%0d a%h", i, ad), rd[i], e_rd);
        req[i] = 1'b0;
      end
      if (c == lat + 1)
        check($sformatf("rdhold i%0d", i), rd[i], e_rd);
    end
    last_rd[i] = e_rd;
  endtask

  initial begin
    logic [31:0] ad;
    int          sel;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0;
      we[i]  = 1'b0;
      a[i]   = 32'd0;
      wd[i]  = 32'd0;
      last_rd[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst ack%0d", i), {31'd0, ack[i]}, 32'd0);
      check($sformatf("rst err%0d", i), {31'd0, err[i]}, 32'd0);
      check($sformatf("rst busy%0d", i), {31'd0, busy[i]}, 32'd0);
      check($sformatf("rst rd%0d", i), rd[i], 32'd0);
    end

    // Preload every word of every instance.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 64; k++)
        xfer(i, 1'b1, k * 4, $urandom, 0, 32'd0);

    // Write then read, latency 2.
    xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 0, 32'd0);
    xfer(1, 1'b0, 32'h10, 32'd0, 0, 32'd0);
    check("wr_rd deadbeef", rd[1], 32'hDEADBEEF);

    // Back-to-back reads with req held, latency 1.
    xfer(0, 1'b1, 32'h0, 32'd1, 0, 32'd0);
    xfer(0, 1'b1, 32'h4, 32'd2, 0, 32'd0);
    xfer(0, 1'b1, 32'h8, 32'd3, 0, 32'd0);
    @(negedge clk);
    req[0] = 1'b1;
    we[0]  = 1'b0;
    a[0]   = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("b2b ack c%0d", c), {31'd0, ack[0]},
            {31'd0, (c % 2) == 1 && c <= 5});
      if (c % 2 == 1 && c <= 5) begin
        check($sformatf("b2b rd c%0d", c), rd[0], 32'((c + 1) / 2));
        a[0] = 32'((c + 1) * 2);
        if (c == 5) req[0] = 1'b0;
      end
    end
    last_rd[0] = 32'd3;

    // Misaligned write and out-of-range read, latency 2.
    xfer(1, 1'b1, 32'h12, 32'h12345678, 0, 32'd0);
    xfer(1, 1'b0, 32'h10, 32'd0, 0, 32'd0);
    check("misalign mem4", rd[1], 32'hDEADBEEF);
    xfer(1, 1'b0, 32'h100, 32'd0, 0, 32'd0);

    // Address changed during WAIT, latency 4.
    xfer(2, 1'b0, 32'h20, 32'd0, 2, 32'h24);

    // Reset during WAIT discards the write, latency 2.
    xfer(1, 1'b1, 32'h0, 32'hAA, 0, 32'd0);
    @(negedge clk);
    req[1] = 1'b1;
    we[1]  = 1'b1;
    a[1]   = 32'h0;
    wd[1]  = 32'h55;
    @(negedge clk);
    check("rstw busy", {31'd0, busy[1]}, 32'd1);
    req[1] = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstw ack", {31'd0, ack[1]}, 32'd0);
    check("rstw busy0", {31'd0, busy[1]}, 32'd0);
    check("rstw rd", rd[1], 32'd0);
    for (int i = 0; i < N; i++) last_rd[i] = 32'd0;
    xfer(1, 1'b0, 32'h0, 32'd0, 0, 32'd0);
    check("rstw keep aa", rd[1], 32'hAA);

    // Latency 15 read.
    xfer(3, 1'b0, 32'h40, 32'd0, 0, 32'd0);

    // Random mix of good, misaligned and out-of-range accesses.
    for (int i = 0; i < N; i++) begin
      for (int n = 0; n < 25; n++) begin
        sel = $urandom_range(0, 9);
        if (sel < 6)      ad = 32'($urandom_range(0, 63)) * 4;
        else if (sel < 8) ad = 32'($urandom_range(0, 63)) * 4 +
                               32'($urandom_range(1, 3));
        else              ad = 32'd256 + ($urandom & 32'h7FFF_FFFF);
        xfer(i, 1'($urandom_range(0, 1)), ad, $urandom, 0, 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
